// File: rtl/mips_pkg.sv
// Shared types and constants for the mini-MIPS front end.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; low byte-offset bits of a target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
interface instr_fetch_unit_if
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  logic                imem_en;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instruction;
  logic [PC_W-1:0]     instr_pc;

  modport master (
    output imem_en, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr_valid, instruction, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  fetch_entry_t    wdata,
  output fetch_entry_t    rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    count = count_q;
    empty = (count_q == '0);
    full  = (count_q == CntW'(DEPTH));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one-deep memory request tracking, redirect squash and issue control.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned    ADDR_W   = 10,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned    DEPTH    = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned    CntW  = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            squash_q, squash_d;

  logic [CntW-1:0] count, occupancy;
  logic            pop, push, issue, full, empty;
  fetch_entry_t    head, wentry;

  always_comb begin
    pop       = ~empty & bus.instr_ready;
    // Slots committed once this cycle settles: buffered + arriving - leaving.
    occupancy = count + CntW'(inflight_q) - CntW'(pop);
    issue     = ~bus.redirect_valid & (occupancy < DepthC);
    // A response arriving during a redirect belongs to the flushed path.
    push      = inflight_q & ~squash_q & ~bus.redirect_valid & (~full | pop);
    wentry    = '{pc: req_pc_q, instr: bus.imem_rdata};

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    squash_d   = 1'b0;
    if (bus.redirect_valid) begin
      pc_d     = align_pc(bus.redirect_pc);
      squash_d = inflight_q;
    end else if (issue) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    bus.imem_en     = issue;
    bus.imem_addr   = pc_q[ADDR_W+1:2];
    bus.instr_valid = ~empty;
    bus.instruction = head.instr;
    bus.instr_pc    = head.pc;
  end

endmodule
